proc_feeder: RTL
================

PROC_FEEDER -- requirements
Module: proc_feeder

Interface
REQ-001 Parameter: DEPTH, default 32, number of 9-bit program words held.
REQ-002 Parameter: TIMEOUT, default 4, EXEC cycles without done before an instruction counts as illegal.
REQ-003 Port: clock  in  1  single clock; all state changes on rising edge.
REQ-004 Port: resetn  in  1  reset, asynchronous and active-low.
REQ-005 Port: load_en  in  1  write load_data into program memory at load_addr.
REQ-006 Port: load_addr  in  5  program memory write address.
REQ-007 Port: load_data  in  9  program word, format III XXX YYY.
REQ-008 Port: prog_len  in  6  number of words to stream, range 0..32; sampled on start.
REQ-009 Port: start  in  1  begin streaming from address 0.
REQ-010 Port: done  in  1  processor completion strobe.
REQ-011 Port: DIN  out  9  word driven to the processor data input.
REQ-012 Port: run  out  1  one-cycle strobe that launches an instruction.
REQ-013 Port: busy  out  1  high from the start accept to finish.
REQ-014 Port: finished  out  1  one-cycle pulse when the program is exhausted.
REQ-015 Port: illegal  out  1  sticky flag, set on a processor timeout, cleared by start.
REQ-016 Port: pc  out  5  address of the current instruction word.

Function
REQ-017 States: IDLE, ISSUE, EXEC, FIN; encoding is 2 bits.
REQ-018 IDLE: run=0, DIN=0; start=1 latches prog_len, clears pc, word count and illegal, then moves to ISSUE, or to FIN if prog_len=0.
REQ-019 ISSUE (exactly one cycle): DIN=mem[pc], run=1; next state EXEC.
REQ-020 EXEC, opcode 001 (mvi): DIN=mem[(pc+1) mod 32] every EXEC cycle, because the processor samples the immediate in its T1.
REQ-021 EXEC, other opcodes: DIN=0; run=0 in every EXEC cycle.
REQ-022 EXEC on done=1: advance pc and word count by 2 for mvi, otherwise by 1; pc wraps mod 32.
REQ-023 After the advance, go to FIN if word count >= latched prog_len, else go to ISSUE.
REQ-024 Expected done latency after ISSUE: 1 cycle for opcodes 000/001, 3 cycles for 010/011.
REQ-025 EXEC timeout: if done stays low for TIMEOUT consecutive cycles, set illegal=1, advance by 1, and apply REQ-023; this covers opcodes 100-111, which the processor drops without asserting done.
REQ-026 FIN: finished=1 for one cycle, busy=0 in the following cycle, then IDLE.
REQ-027 busy=1 in ISSUE, EXEC and FIN.
REQ-028 done seen outside EXEC is ignored.
REQ-029 start while busy is ignored; load_en while busy is ignored.
REQ-030 Memory writes are synchronous; a word written in cycle n is readable in cycle n+1.
REQ-031 Program memory reads are combinational, so DIN is valid in the same cycle as run.
REQ-032 An mvi at the last counted word still fetches its immediate, and streaming then finishes; word count may exceed prog_len by 1.

Reset
REQ-033 resetn=0 immediately forces: state IDLE, run=0, DIN=0, busy=0, finished=0, illegal=0, pc=0, word count=0, timeout counter=0.
REQ-034 Reset asserted mid-program aborts streaming with no finished pulse; program memory contents are not cleared.

Structure
REQ-035 A shared package holds the opcode constants (MV=000, MVI=001, ADD=010, SUB=011), the state encoding, and word width 9.
REQ-036 One sub-module, feeder_mem: DEPTH x 9 RAM with one synchronous write port and two asynchronous read ports (pc and pc+1).

Verification
REQ-037 Load {001_000_000, 9'd5, 000_001_000}, prog_len=3, start -> run pulses at 2 cycles only, DIN=5 in the cycle after the first run, finished one cycle after the second done.
REQ-038 Stream paired with the processor: mvi R0,#3; mvi R1,#4; add R0,R1 -> processor R0=7, finished, illegal=0.
REQ-039 Word 100_000_000 followed by mv, prog_len=2, processor attached -> illegal=1 after 4 EXEC cycles, then the mv issues and finished pulses.
REQ-040 prog_len=0, start -> busy for one cycle, finished pulses, run never asserted.
REQ-041 resetn low during EXEC of an add -> run=0, busy=0, pc=0 with no clock edge; restart replays from address 0 with memory intact.
REQ-042 start and load_en held high while busy -> no restart, memory unchanged; re-reading memory afterwards matches the original program.

Source files
------------

// File: rtl/proc_feeder_pkg.sv
// Shared definitions for the program feeder: word format, opcodes and FSM encoding.
// Program words are III XXX YYY: a 3-bit opcode followed by two register fields.
package proc_feeder_pkg;

  localparam int WORD_W = 9;
  localparam int ADDR_W = 5;
  localparam int LEN_W  = 6;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/feeder_mem.sv
// Program RAM: one synchronous write port, two combinational read ports so the
// instruction word and the following immediate are both available in the same cycle.
module feeder_mem
  import proc_feeder_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  word_t             i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output word_t             o_rdata_a,
  output word_t             o_rdata_b
);

  word_t r_mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM and survives a mid-program reset.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/proc_feeder.sv
// Streams a stored program into a simple processor: one run strobe per instruction,
// the mvi immediate presented during execution, and a timeout for dropped opcodes.
module proc_feeder
  import proc_feeder_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load_en,
  input  logic [4:0] load_addr,
  input  logic [8:0] load_data,
  input  logic [5:0] prog_len,
  input  logic       start,
  input  logic       done,
  output logic [8:0] DIN,
  output logic       run,
  output logic       busy,
  output logic       finished,
  output logic       illegal,
  output logic [4:0] pc
);

  localparam int CNT_W = LEN_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_illegal;

  word_t              w_word_pc;
  word_t              w_word_nx;
  logic [ADDR_W-1:0]  w_pc_nx;
  logic               w_is_mvi;
  logic [1:0]         w_step;
  logic [ADDR_W-1:0]  w_pc_adv;
  logic [CNT_W-1:0]   w_cnt_adv;
  logic               w_mem_we;

  assign w_pc_nx   = r_pc + ADDR_W'(1);
  assign w_mem_we  = load_en && (r_state == ST_IDLE);
  assign w_is_mvi  = (w_word_pc[WORD_W-1 -: OP_W] == OP_MVI);
  // A timeout advances by one word even for an mvi, since nothing consumed the immediate.
  assign w_step    = (done && w_is_mvi) ? 2'd2 : 2'd1;
  assign w_pc_adv  = r_pc + ADDR_W'(w_step);
  assign w_cnt_adv = r_cnt + CNT_W'(w_step);

  feeder_mem #(.DEPTH(DEPTH)) u_mem (
    .clock     (clock),
    .i_we      (w_mem_we),
    .i_waddr   (load_addr),
    .i_wdata   (load_data),
    .i_raddr_a (r_pc),
    .i_raddr_b (w_pc_nx),
    .o_rdata_a (w_word_pc),
    .o_rdata_b (w_word_nx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_tmo     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len     <= prog_len;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_illegal <= 1'b0;
            r_state   <= (prog_len == '0) ? ST_FIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tmo   <= '0;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (done || (r_tmo == TMO_LAST)) begin
            r_pc    <= w_pc_adv;
            r_cnt   <= w_cnt_adv;
            r_tmo   <= '0;
            if (!done) r_illegal <= 1'b1;
            r_state <= (w_cnt_adv >= {1'b0, r_len}) ? ST_FIN : ST_ISSUE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: DIN gets a default before the case so no path through the block infers a latch.
  always_comb begin
    DIN = '0;
    case (r_state)
      ST_ISSUE: DIN = w_word_pc;
      ST_EXEC:  if (w_is_mvi) DIN = w_word_nx;
      default:  DIN = '0;
    endcase
  end

  assign run      = (r_state == ST_ISSUE);
  assign busy     = (r_state != ST_IDLE);
  assign finished = (r_state == ST_FIN);
  assign illegal  = r_illegal;
  assign pc       = r_pc;

endmodule
